icache_nway_block: RTL and testbench

- Parametrised successor to the current single-word direct-mapped instruction cache.
- Direct-mapped, with configurable set count and a multi-word block: a miss refills the whole block from memory, one word per memory handshake.
- Adds a full-cache invalidate (flush) and latches the miss address, so a refill always completes for the address that missed.
- Sits between the datapath fetch port and the memory-side icache port.

---
 rtl/icache_nway_block.sv | 160 ++++++++++++++++
 tb/tb_icache_nway_block.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway_block.sv
// rtl/icache_nway_block.sv - direct-mapped instruction cache with multi-word blocks and flush
module icache_nway_block #(
   parameter int SETS            = 16,
   parameter int WORDS_PER_BLOCK = 2,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              imemREN,
   input  logic [ADDR_W-1:0] imemaddr,
   output logic              ihit,
   output logic [DATA_W-1:0] imemload,
   input  logic              flush,
   output logic              flush_done,
   output logic              iREN,
   output logic [ADDR_W-1:0] iaddr,
   input  logic [DATA_W-1:0] iload,
   input  logic              iwait
);
   localparam int WOFF   = $clog2(WORDS_PER_BLOCK);
   localparam int IDX    = $clog2(SETS);
   localparam int WOFF_W = (WOFF > 0) ? WOFF : 1;
   localparam int TAG_W  = ADDR_W - 2 - WOFF - IDX;
   localparam int CNT_W  = WOFF + 1;
   localparam int FCNT_W = IDX + 1;

   typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
   logic                flush_pend_q, flush_pend_d;
   logic                flush_prev_q;
   logic [SETS-1:0]     valid_q, valid_d;
   logic                iren_q, iren_d;
   logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
   logic                flush_done_q, flush_done_d;

   logic [TAG_W-1:0]    tag_mem  [SETS];
   logic [DATA_W-1:0]   data_mem [SETS][WORDS_PER_BLOCK];

   logic [IDX-1:0]      req_idx, miss_idx;
   logic [TAG_W-1:0]    req_tag, miss_tag;
   logic [WOFF_W-1:0]   req_woff;
   logic                hit, flush_rise, last_word, fill_we;

   assign req_idx    = imemaddr[2+WOFF +: IDX];
   assign req_tag    = imemaddr[ADDR_W-1 -: TAG_W];
   assign req_woff   = imemaddr[2 +: WOFF_W] & WOFF_W'(WORDS_PER_BLOCK - 1);
   assign miss_idx   = miss_addr_q[2+WOFF +: IDX];
   assign miss_tag   = miss_addr_q[ADDR_W-1 -: TAG_W];
   assign flush_rise = flush & ~flush_prev_q;
   assign last_word  = (cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));
   assign fill_we    = (state_q == REFILL) && !iwait;

   // zero-latency hit lookup, only while idle
   always_comb begin
      hit      = (state_q == IDLE) && imemREN && valid_q[req_idx] &&
                 (tag_mem[req_idx] == req_tag);
      ihit     = hit;
      imemload = hit ? data_mem[req_idx][req_woff] : '0;
   end

   // next-state, counters, valid bits and the registered memory-side outputs
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fcnt_d       = fcnt_q;
      miss_addr_d  = miss_addr_q;
      flush_pend_d = flush_pend_q;
      valid_d      = valid_q;
      case (state_q)
         IDLE: begin
            if (flush_rise) begin
               state_d = FLUSH;
               fcnt_d  = '0;
            end else if (imemREN && !hit) begin
               // the victim frame is invalidated now so a half-filled block never hits
               miss_addr_d      = imemaddr;
               cnt_d            = '0;
               valid_d[req_idx] = 1'b0;
               state_d          = REFILL;
            end
         end
         REFILL: begin
            if (flush_rise) flush_pend_d = 1'b1;
            if (!iwait) begin
               if (last_word) begin
                  valid_d[miss_idx] = 1'b1;
                  cnt_d             = '0;
                  if (flush_pend_q || flush_rise) begin
                     state_d      = FLUSH;
                     fcnt_d       = '0;
                     flush_pend_d = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         FLUSH: begin
            valid_d[fcnt_q[IDX-1:0]] = 1'b0;
            if (fcnt_q == FCNT_W'(SETS - 1)) begin
               state_d = IDLE;
               fcnt_d  = '0;
            end else begin
               fcnt_d = fcnt_q + FCNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      iren_d       = (state_d == REFILL);
      iaddr_d      = iren_d ? ((miss_addr_d & ~ADDR_W'(WORDS_PER_BLOCK * 4 - 1)) +
                               (ADDR_W'(cnt_d) << 2)) : '0;
      flush_done_d = (state_d == FLUSH) && (fcnt_d == FCNT_W'(SETS - 1));
   end

   // control state and outputs, cleared asynchronously
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         fcnt_q       <= '0;
         miss_addr_q  <= '0;
         flush_pend_q <= 1'b0;
         flush_prev_q <= 1'b0;
         valid_q      <= '0;
         iren_q       <= 1'b0;
         iaddr_q      <= '0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fcnt_q       <= fcnt_d;
         miss_addr_q  <= miss_addr_d;
         flush_pend_q <= flush_pend_d;
         flush_prev_q <= flush;
         valid_q      <= valid_d;
         iren_q       <= iren_d;
         iaddr_q      <= iaddr_d;
         flush_done_q <= flush_done_d;
      end
   end

   // tag and data arrays need no reset; valid bits guard them
   always_ff @(posedge CLK) begin
      if (fill_we) begin
         data_mem[miss_idx][cnt_q[WOFF_W-1:0]] <= iload;
         if (last_word) tag_mem[miss_idx] <= miss_tag;
      end
   end

   assign iREN       = iren_q;
   assign iaddr      = iaddr_q;
   assign flush_done = flush_done_q;
endmodule

// File: tb/tb_icache_nway_block.sv
// tb/tb_icache_nway_block.sv - self-checking bench for icache_nway_block
module tb_icache_nway_block;
   localparam int SETS = 16;
   localparam int WPB  = 2;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        imemREN = 1'b0;
   logic [31:0] imemaddr = '0;
   logic        ihit;
   logic [31:0] imemload;
   logic        flush = 1'b0;
   logic        flush_done;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait = 1'b0;

   int errs = 0;
   int checks = 0;
   bit armed = 0;
   int slow_wait = 0;
   int wctr = 0;

   icache_nway_block #(.SETS(SETS), .WORDS_PER_BLOCK(WPB), .ADDR_W(32), .DATA_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .flush(flush), .flush_done(flush_done),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A0000;
   endfunction

   assign iload = mem_word(iaddr);

   // memory responder: slow_wait busy cycles before each word
   always @(negedge CLK) begin
      if (iREN && wctr < slow_wait) begin
         iwait = 1'b1;
         wctr++;
      end else begin
         iwait = 1'b0;
         wctr = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_val [SETS];
   logic [31:0] m_tag [SETS];
   logic [31:0] m_dat [SETS][WPB];
   logic [31:0] fq[$];
   int          flush_left = 0;
   bit          pend = 0;
   bit          prev_fl = 0;

   function automatic int m_idx(input logic [31:0] a);
      return int'(((a >> 2) / WPB) % SETS);
   endfunction
   function automatic logic [31:0] m_tg(input logic [31:0] a);
      return (a >> 2) / (WPB * SETS);
   endfunction
   function automatic int m_wd(input logic [31:0] a);
      return int'((a >> 2) % WPB);
   endfunction
   function automatic bit m_hit(input logic [31:0] a);
      return m_val[m_idx(a)] && (m_tag[m_idx(a)] == m_tg(a));
   endfunction

   always @(posedge CLK or negedge nRST) begin : model
      logic [31:0] a;
      bit rise;
      if (!nRST) begin
         fq.delete();
         flush_left = 0;
         pend = 0;
         prev_fl = 0;
         for (int i = 0; i < SETS; i++) m_val[i] = 0;
      end else begin
         rise = flush && !prev_fl;
         if (fq.size() > 0) begin
            if (rise) pend = 1;
            if (!iwait) begin
               a = fq.pop_front();
               m_dat[m_idx(a)][m_wd(a)] = mem_word(a);
               if (fq.size() == 0) begin
                  m_val[m_idx(a)] = 1;
                  m_tag[m_idx(a)] = m_tg(a);
                  if (pend) begin
                     flush_left = SETS;
                     pend = 0;
                  end
               end
            end
         end else if (flush_left > 0) begin
            m_val[SETS - flush_left] = 0;
            flush_left--;
         end else if (rise) begin
            flush_left = SETS;
         end else if (imemREN && !m_hit(imemaddr)) begin
            m_val[m_idx(imemaddr)] = 0;
            a = imemaddr & ~(32'(4 * WPB) - 32'd1);
            for (int w = 0; w < WPB; w++) fq.push_back(a + 32'(4 * w));
         end
         prev_fl = flush;
      end
   end

   // per-cycle comparison against the model
   always @(negedge CLK) begin : compare
      bit e_hit;
      logic [31:0] e_load;
      if (armed) begin
         if (fq.size() > 0) begin
            chk("m_iren", {31'd0, iREN}, 32'd1);
            chk("m_iaddr", iaddr, fq[0]);
            chk("m_ihit", {31'd0, ihit}, 32'd0);
            chk("m_fdone", {31'd0, flush_done}, 32'd0);
         end else if (flush_left > 0) begin
            chk("m_iren", {31'd0, iREN}, 32'd0);
            chk("m_ihit", {31'd0, ihit}, 32'd0);
            chk("m_fdone", {31'd0, flush_done}, {31'd0, flush_left == 1});
         end else begin
            e_hit  = imemREN && m_hit(imemaddr);
            e_load = e_hit ? m_dat[m_idx(imemaddr)][m_wd(imemaddr)] : 32'd0;
            chk("m_iren", {31'd0, iREN}, 32'd0);
            chk("m_ihit", {31'd0, ihit}, {31'd0, e_hit});
            chk("m_load", imemload, e_load);
            chk("m_fdone", {31'd0, flush_done}, 32'd0);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_hit(input int max);
      int n = 0;
      #1;
      while (!ihit && n < max) begin
         step();
         #1;
         n++;
      end
      chk("wait_hit", {31'd0, ihit}, 32'd1);
   endtask

   initial begin
      step();
      step();
      armed = 1;
      #1;
      chk("rst_iren", {31'd0, iREN}, 32'd0);
      chk("rst_ihit", {31'd0, ihit}, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      chk("rst_load", imemload, 32'd0);
      chk("rst_fdone", {31'd0, flush_done}, 32'd0);
      step();
      nRST = 1'b1;

      // 1: cold miss at 0x40
      step();
      imemREN = 1'b1;
      imemaddr = 32'h40;
      #1 chk("s1_miss", {31'd0, ihit}, 32'd0);
      step(); #1;
      chk("s1_iren0", {31'd0, iREN}, 32'd1);
      chk("s1_iaddr0", iaddr, 32'h40);
      step(); #1;
      chk("s1_iaddr1", iaddr, 32'h44);
      step(); #1;
      chk("s1_hit", {31'd0, ihit}, 32'd1);
      chk("s1_load", imemload, 32'h5A5A0040);
      imemaddr = 32'h44;
      #1;
      chk("s1_hit44", {31'd0, ihit}, 32'd1);
      chk("s1_load44", imemload, 32'h5A5A0044);

      // 2: conflict at index 8
      step();
      imemaddr = 32'h440;
      step(); #1;
      chk("s2_iaddr0", iaddr, 32'h440);
      step(); #1;
      chk("s2_iaddr1", iaddr, 32'h444);
      step(); #1;
      chk("s2_load", imemload, 32'h5A5A0440);
      imemaddr = 32'h40;
      #1 chk("s2_evicted", {31'd0, ihit}, 32'd0);
      step();
      wait_hit(10);

      // 3: slow memory, address change mid-refill ignored
      step();
      imemaddr = 32'h440;
      wait_hit(10);
      step();
      slow_wait = 3;
      imemaddr = 32'h40;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 2) imemaddr = 32'h80;
         #1;
         chk("s3_iren", {31'd0, iREN}, 32'd1);
         chk("s3_iaddr", iaddr, (i < 4) ? 32'h40 : 32'h44);
      end
      step();
      imemaddr = 32'h40;
      #1;
      chk("s3_hit", {31'd0, ihit}, 32'd1);
      chk("s3_load", imemload, 32'h5A5A0040);
      chk("s3_idle", {31'd0, iREN}, 32'd0);
      slow_wait = 0;

      // 4: flush after filling indices 0..3
      for (int k = 0; k < 4; k++) begin
         step();
         imemaddr = 32'(8 * k);
         wait_hit(10);
      end
      step();
      imemREN = 1'b0;
      flush = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         flush = 1'b0;
         imemREN = 1'b1;
         imemaddr = 32'h0;
         #1;
         chk("s4_nohit", {31'd0, ihit}, 32'd0);
         chk("s4_fdone", {31'd0, flush_done}, {31'd0, i == 15});
      end
      step(); #1;
      chk("s4_miss0", {31'd0, ihit}, 32'd0);
      chk("s4_fdone_end", {31'd0, flush_done}, 32'd0);
      step(); #1;
      chk("s4_refill0", iaddr, 32'h0);
      wait_hit(10);

      // 5: flush during refill
      step();
      imemaddr = 32'h100;
      #1 chk("s5_miss", {31'd0, ihit}, 32'd0);
      step();
      flush = 1'b1;
      #1 chk("s5_iaddr0", iaddr, 32'h100);
      step();
      flush = 1'b0;
      #1 chk("s5_iaddr1", iaddr, 32'h104);
      for (int i = 0; i < 16; i++) begin
         step(); #1;
         chk("s5_iren", {31'd0, iREN}, 32'd0);
         chk("s5_fdone", {31'd0, flush_done}, {31'd0, i == 15});
      end
      step(); #1;
      chk("s5_miss_after", {31'd0, ihit}, 32'd0);
      wait_hit(10);

      // 6: asynchronous reset mid-refill
      step();
      imemaddr = 32'h440;
      wait_hit(10);
      step();
      imemaddr = 32'h40;
      step();
      #2 nRST = 1'b0;
      #1 chk("s6_iren_drop", {31'd0, iREN}, 32'd0);
      step();
      step();
      nRST = 1'b1;
      imemREN = 1'b0;
      step();
      imemREN = 1'b1;
      imemaddr = 32'h440;
      #1 chk("s6_miss", {31'd0, ihit}, 32'd0);
      wait_hit(10);

      step();
      imemREN = 1'b0;
      step();
      step();
      armed = 0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
